fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the RISC-V core. Owns the program counter, issues word-aligned read requests to the instruction memory over a valid/ready handshake, and buffers the returned instructions with their PCs in a small FIFO for decode and the immediate generator. Handles front-end stalls, branch/jump redirects, and discarding of stale in-flight responses.

---
 rtl/fetch_ctrl_if.sv | 24 ++
 rtl/fetch_ctrl.sv | 98 +++++++++
 tb/tb_fetch_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect, and decode handoff.
// The master side is the fetch sequencer; the slave side is the memory/decode environment.
interface fetch_ctrl_if #(parameter int XLEN = 64);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight and
// queues returned words with their PCs in a small FIFO for decode.
module fetch_ctrl #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2,
  parameter logic [31:0]     NOP       = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_pc, r_req_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [31:0]     r_ibuf [BUF_DEPTH];
  logic [XLEN-1:0] r_pbuf [BUF_DEPTH];

  logic            w_redir, w_req, w_accept, w_push, w_pop;
  logic [XLEN-1:0] w_redir_pc;

  // A redirect seen in IDLE is dropped: nothing has been fetched yet.
  assign w_redir    = bus.redirect_valid && (r_state != S_IDLE);
  assign w_redir_pc = bus.redirect_pc & ~XLEN'(3);
  assign w_req      = (r_state == S_REQ) && !bus.redirect_valid && (r_count < DEPTH_C);
  assign w_accept   = w_req && bus.imem_ready;
  assign w_push     = (r_state == S_WAIT) && bus.imem_rvalid && !w_redir;
  assign w_pop      = bus.if_valid && bus.if_ready && !w_redir;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = (r_count != '0);
  assign bus.if_instr  = bus.if_valid ? r_ibuf[r_rptr] : NOP;
  assign bus.if_pc     = bus.if_valid ? r_pbuf[r_rptr] : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_REQ;
      S_REQ:   if (w_accept) w_next = S_WAIT;
      // Redirect without the response yet: the stale word must still be swallowed.
      S_WAIT:  if (bus.imem_rvalid) w_next = S_REQ;
               else if (w_redir) w_next = S_DRAIN;
      S_DRAIN: if (bus.imem_rvalid) w_next = S_REQ;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      r_state <= w_next;
      if (w_redir) begin
        r_pc <= w_redir_pc;
      end else if (w_accept) begin
        r_pc     <= r_pc + XLEN'(4);
        r_req_pc <= r_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (w_redir) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ibuf[r_wptr] <= bus.imem_rdata;
      r_pbuf[r_wptr] <= r_req_pc;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory returns the word index of the address,
// expected decode handoffs are queued by the stimulus and checked on every pop.
module tb_fetch_ctrl;
  logic clk, rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];

  fetch_ctrl_if #(.XLEN(64)) ifa ();
  fetch_ctrl_if #(.XLEN(64)) ifb ();

  fetch_ctrl #(.XLEN(64), .RESET_PC(64'h0), .BUF_DEPTH(2), .NOP(32'h0000_0013))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  fetch_ctrl #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .BUF_DEPTH(2), .NOP(32'h0000_0013))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory models (rvalid one cycle after accept) plus a manual override for A.
  logic        auto_a, man_rv;
  logic [31:0] man_d;
  logic        ra_rv, rb_rv;
  logic [31:0] ra_d, rb_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_rv <= 1'b0; ra_d <= '0; rb_rv <= 1'b0; rb_d <= '0;
    end else begin
      ra_rv <= ifa.imem_req & ifa.imem_ready;
      ra_d  <= ifa.imem_addr[33:2];
      rb_rv <= ifb.imem_req & ifb.imem_ready;
      rb_d  <= ifb.imem_addr[33:2];
    end
  end

  assign ifa.imem_rvalid = auto_a ? ra_rv : man_rv;
  assign ifa.imem_rdata  = auto_a ? ra_d  : man_d;
  assign ifb.imem_rvalid = rb_rv;
  assign ifb.imem_rdata  = rb_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.pc = pc;
    e.instr = 32'(pc >> 2);
    sb.push_back(e);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},   64'(ifa.imem_req), 64'd0);
    chk({tag, "_addr"},  ifa.imem_addr, 64'd0);
    chk({tag, "_valid"}, 64'(ifa.if_valid), 64'd0);
    chk({tag, "_instr"}, 64'(ifa.if_instr), 64'h13);
    chk({tag, "_pc"},    ifa.if_pc, 64'd0);
  endtask

  // Scoreboard: every decode handshake on A must match the next queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && ifa.if_valid && ifa.if_ready) begin
      e.pc = '1;
      e.instr = '0;
      if (sb.size() != 0) e = sb.pop_front();
      chk("pop_pc", ifa.if_pc, e.pc);
      chk("pop_instr", 64'(ifa.if_instr), 64'(e.instr));
    end
  end

  initial begin
    rst_n = 1'b0; auto_a = 1'b1; man_rv = 1'b0; man_d = '0;
    ifa.imem_ready = 1'b1; ifa.redirect_valid = 1'b0; ifa.redirect_pc = '0; ifa.if_ready = 1'b1;
    ifb.imem_ready = 1'b1; ifb.redirect_valid = 1'b0; ifb.redirect_pc = '0; ifb.if_ready = 1'b1;
    tick(); tick();
    chk_reset_outs("rst");

    // c0: reset released, IDLE
    rst_n = 1'b1; #1;
    chk("c0_req", 64'(ifa.imem_req), 64'd0);
    push_exp(64'h0); push_exp(64'h4); push_exp(64'h8);
    tick(); #1;                                   // c1
    chk("c1_req", 64'(ifa.imem_req), 64'd1);
    chk("c1_addr", ifa.imem_addr, 64'h0);
    chk("b_c1_addr", ifb.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); #1;                                   // c2
    chk("c2_req", 64'(ifa.imem_req), 64'd0);
    chk("c2_valid", 64'(ifa.if_valid), 64'd0);
    chk("c2_nop", 64'(ifa.if_instr), 64'h13);
    tick(); #1;                                   // c3
    chk("c3_valid", 64'(ifa.if_valid), 64'd1);
    chk("c3_addr", ifa.imem_addr, 64'h4);
    chk("b_wrap_addr", ifb.imem_addr, 64'h0);
    chk("b_head_pc", ifb.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("b_head_instr", 64'(ifb.if_instr), 64'hFFFF_FFFF);
    tick(); tick(); tick(); tick(); #1;           // c7
    chk("c7_addr", ifa.imem_addr, 64'hC);

    // Backpressure: buffer fills to two entries, then requests stop.
    tick(); ifa.if_ready = 1'b0; #1;              // c8
    push_exp(64'hC); push_exp(64'h10);
    tick(); #1;                                   // c9
    chk("c9_req", 64'(ifa.imem_req), 64'd1);
    chk("c9_addr", ifa.imem_addr, 64'h10);
    tick(); tick(); #1;                           // c11
    chk("c11_req", 64'(ifa.imem_req), 64'd0);
    chk("c11_addr", ifa.imem_addr, 64'h14);
    for (int i = 0; i < 6; i++) tick();
    #1;                                           // c17
    chk("c17_req", 64'(ifa.imem_req), 64'd0);
    chk("c17_head", ifa.if_pc, 64'hC);
    tick(); ifa.if_ready = 1'b1; #1;              // c18
    chk("c18_req", 64'(ifa.imem_req), 64'd0);
    tick(); #1;                                   // c19
    chk("c19_req", 64'(ifa.imem_req), 64'd1);
    chk("c19_addr", ifa.imem_addr, 64'h14);
    tick(); tick();                               // c21: pc 0x14 buffered, then flushed

    ifa.if_ready = 1'b0; ifa.redirect_valid = 1'b1; ifa.redirect_pc = 64'h1002; #1;
    chk("c21_head", ifa.if_pc, 64'h14);
    chk("c21_req", 64'(ifa.imem_req), 64'd0);
    tick(); ifa.redirect_valid = 1'b0; ifa.if_ready = 1'b1; #1;   // c22
    chk("c22_req", 64'(ifa.imem_req), 64'd1);
    chk("c22_addr", ifa.imem_addr, 64'h1000);
    chk("c22_valid", 64'(ifa.if_valid), 64'd0);
    push_exp(64'h1000);
    tick(); tick(); auto_a = 1'b0; #1;            // c24
    chk("c24_addr", ifa.imem_addr, 64'h1004);

    // Redirect while a request is outstanding; stale word arrives three cycles later.
    tick(); ifa.redirect_valid = 1'b1; ifa.redirect_pc = 64'h2000; #1;   // c25
    chk("c25_req", 64'(ifa.imem_req), 64'd0);
    tick(); ifa.redirect_valid = 1'b0; #1;        // c26
    chk("c26_req", 64'(ifa.imem_req), 64'd0);
    chk("c26_valid", 64'(ifa.if_valid), 64'd0);
    tick(); #1;                                   // c27
    chk("c27_req", 64'(ifa.imem_req), 64'd0);
    tick(); man_rv = 1'b1; man_d = 32'hDEAD_BEEF; #1;   // c28
    chk("c28_req", 64'(ifa.imem_req), 64'd0);
    tick(); man_rv = 1'b0; #1;                    // c29
    chk("c29_req", 64'(ifa.imem_req), 64'd1);
    chk("c29_addr", ifa.imem_addr, 64'h2000);
    tick(); man_rv = 1'b1; man_d = 32'h800; push_exp(64'h2000); #1;   // c30
    tick(); man_rv = 1'b0; ifa.if_ready = 1'b0; #1;                   // c31
    chk("c31_head", ifa.if_pc, 64'h2000);
    chk("c31_addr", ifa.imem_addr, 64'h2004);

    // Redirect, rvalid and pop together: head consumed, new word discarded.
    tick(); man_rv = 1'b1; man_d = 32'h801;       // c32
    ifa.redirect_valid = 1'b1; ifa.redirect_pc = 64'h3000; ifa.if_ready = 1'b1; #1;
    chk("c32_req", 64'(ifa.imem_req), 64'd0);
    tick(); man_rv = 1'b0; ifa.redirect_valid = 1'b0; #1;   // c33
    chk("c33_valid", 64'(ifa.if_valid), 64'd0);
    chk("c33_req", 64'(ifa.imem_req), 64'd1);
    chk("c33_addr", ifa.imem_addr, 64'h3000);
    push_exp(64'h3000);
    tick(); man_rv = 1'b1; man_d = 32'hC00; #1;   // c34
    tick(); man_rv = 1'b0; #1;                    // c35
    chk("c35_head", ifa.if_pc, 64'h3000);

    // Reset pulse mid-WAIT, then a late response that must be ignored.
    tick(); rst_n = 1'b0; #1;                     // c36
    chk_reset_outs("mid_rst");
    tick(); rst_n = 1'b1; man_rv = 1'b1; man_d = 32'h0BAD; #1;   // c37
    chk("c37_req", 64'(ifa.imem_req), 64'd0);
    tick(); ifa.imem_ready = 1'b0; #1;            // c38
    chk("c38_req", 64'(ifa.imem_req), 64'd1);
    chk("c38_addr", ifa.imem_addr, 64'h0);
    tick(); man_rv = 1'b0; ifa.imem_ready = 1'b1; #1;   // c39
    chk("c39_addr_hold", ifa.imem_addr, 64'h0);
    chk("c39_valid", 64'(ifa.if_valid), 64'd0);
    push_exp(64'h0);
    tick(); man_rv = 1'b1; man_d = 32'h0; #1;     // c40
    tick(); man_rv = 1'b0; #1;                    // c41
    chk("c41_valid", 64'(ifa.if_valid), 64'd1);
    chk("c41_pc", ifa.if_pc, 64'h0);
    tick(); tick(); #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
